pwm_fade_ctrl: RTL

- Memory-mapped controller that schedules duty-cycle fades for NCH PWM channels sharing one 8-bit PWM counter.
- Software writes a target duty and a step. A shared prescaler tick starts a round-robin scan that moves each channel's current duty one step toward its target.
- Sits on the CPU peripheral bus (valid/ready/wstrb/addr/wdata/rdata) and drives LED/motor pins directly.

---
 rtl/pwm_fade_pkg.sv | 31 +++
 rtl/pwm_fade_tick.sv | 23 ++
 rtl/pwm_fade_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_fade_pkg.sv
// rtl/pwm_fade_pkg.sv - register offsets, FSM states and byte-lane helpers for pwm_fade_ctrl
package pwm_fade_pkg;

    localparam logic [1:0] CUR_OFS      = 2'd0;
    localparam logic [1:0] TARGET_OFS   = 2'd1;
    localparam logic [1:0] STEP_OFS     = 2'd2;
    localparam logic [5:0] STATUS_ADDR  = 6'h20;
    localparam logic [5:0] IRQEN_ADDR   = 6'h21;
    localparam logic [5:0] TICKDIV_ADDR = 6'h22;

    typedef enum logic {IDLE, SCAN} fade_state_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] wstrb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = wstrb[b] ? wdata[8*b +: 8] : old[8*b +: 8];
        end
        return r;
    endfunction

    // Byte lanes that overlap a register of the given bit width.
    function automatic logic [3:0] lane_mask(input int width);
        logic [3:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b] = (8 * b < width);
        end
        return m;
    endfunction

endpackage

// File: rtl/pwm_fade_tick.sv
// rtl/pwm_fade_tick.sv - free-running prescaler, one-cycle tick every tickdiv+1 cycles
module pwm_fade_tick #(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [PW-1:0] tickdiv,
    output logic          tick
);
    logic [PW-1:0] cnt;

    assign tick = (cnt == tickdiv);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - bus-mapped duty fader for NCH PWM channels; PWM_FADE_GAMMA_EN selects square-law duty
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int PW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           valid,
    output logic           ready,
    input  logic [3:0]     wstrb,
    input  logic [31:0]    addr,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata,
    output logic [NCH-1:0] pwm_out,
    output logic           irq
);
    logic [DW-1:0]  cur      [NCH];
    logic [DW-1:0]  tgt      [NCH];
    logic [DW-1:0]  step     [NCH];
    logic [DW-1:0]  duty_eff [NCH];
    logic [NCH-1:0] done, irq_en, busy, done_set, done_clr;
    logic [PW-1:0]  tickdiv;
    logic [DW-1:0]  pcnt;
    fade_state_e    state;
    logic [2:0]     idx;
    logic           tick, tick_pending;

    logic [5:0]    word;
    logic [2:0]    ch_sel;
    logic [1:0]    ofs;
    logic          req, wr, ch_reg, conflict, eng_en, eng_land;
    logic          hit_dw, hit_nch, hit_pw;
    logic [31:0]   rd_val, wv;
    logic [DW-1:0] cur_s, tgt_s, step_s, step_e, eng_cur;
    logic [DW:0]   up_sum;

    assign word     = addr[7:2];
    assign ch_sel   = word[4:2];
    assign ofs      = word[1:0];
    assign req      = valid && !ready;
    assign wr       = req && (wstrb != 4'd0);
    assign ch_reg   = (word < 6'(NCH * 4)) && (ofs != 2'd3);
    assign wv       = strb_merge(rd_val, wdata, wstrb);
    assign hit_dw   = |(wstrb & lane_mask(DW));
    assign hit_nch  = |(wstrb & lane_mask(NCH));
    assign hit_pw   = |(wstrb & lane_mask(PW));
    assign irq      = |(done & irq_en);

    logic unused_bits;
    assign unused_bits = &{1'b0, addr[31:8], addr[1:0], wv};

    pwm_fade_tick #(.PW(PW)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .tickdiv (tickdiv),
        .tick    (tick)
    );

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            busy[c] = (cur[c] != tgt[c]);
        end
    end

    always_comb begin
        rd_val = '0;
        if (ch_reg) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_sel == 3'(c)) begin
                    case (ofs)
                        CUR_OFS:    rd_val[DW-1:0] = cur[c];
                        TARGET_OFS: rd_val[DW-1:0] = tgt[c];
                        default:    rd_val[DW-1:0] = step[c];
                    endcase
                end
            end
        end else if (word == STATUS_ADDR) begin
            rd_val[NCH-1:0] = busy;
            rd_val[NCH+7:8] = done;
        end else if (word == IRQEN_ADDR) begin
            rd_val[NCH-1:0] = irq_en;
        end else if (word == TICKDIV_ADDR) begin
            rd_val[PW-1:0] = tickdiv;
        end
    end

    // Step engine for the channel under scan; DW+1 bit math so nothing wraps at 0 or full scale.
    always_comb begin
        cur_s  = '0;
        tgt_s  = '0;
        step_s = '0;
        for (int c = 0; c < NCH; c++) begin
            if (idx == 3'(c)) begin
                cur_s  = cur[c];
                tgt_s  = tgt[c];
                step_s = step[c];
            end
        end
        step_e  = (step_s == '0) ? DW'(1) : step_s;
        up_sum  = {1'b0, cur_s} + {1'b0, step_e};
        eng_cur = cur_s;
        if (cur_s < tgt_s) begin
            eng_cur = (up_sum >= {1'b0, tgt_s}) ? tgt_s : up_sum[DW-1:0];
        end else if (cur_s > tgt_s) begin
            eng_cur = ({1'b0, cur_s} <= ({1'b0, tgt_s} + {1'b0, step_e})) ? tgt_s : (cur_s - step_e);
        end
        eng_land = (cur_s != tgt_s) && (eng_cur == tgt_s);
    end

    assign conflict = wr && ch_reg && (ch_sel == idx);
    assign eng_en   = (state == SCAN) && !conflict;

    always_comb begin
        done_set = '0;
        for (int c = 0; c < NCH; c++) begin
            if (eng_en && eng_land && (idx == 3'(c))) begin
                done_set[c] = 1'b1;
            end
        end
        done_clr = (wr && (word == STATUS_ADDR) && wstrb[1]) ? wdata[NCH+7:8] : '0;
    end

`ifdef PWM_FADE_GAMMA_EN
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            duty_eff[c] = DW'(((2*DW)'(cur[c]) * (2*DW)'(cur[c])) >> DW);
        end
    end
`else
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            duty_eff[c] = cur[c];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                cur[c]  <= '0;
                tgt[c]  <= '0;
                step[c] <= '0;
            end
            done    <= '0;
            irq_en  <= '0;
            tickdiv <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (eng_en && (idx == 3'(c))) begin
                    cur[c] <= eng_cur;
                end
                if (wr && ch_reg && (ch_sel == 3'(c)) && hit_dw) begin
                    case (ofs)
                        CUR_OFS: begin
                            cur[c] <= wv[DW-1:0];
                            tgt[c] <= wv[DW-1:0];
                        end
                        TARGET_OFS: tgt[c]  <= wv[DW-1:0];
                        default:    step[c] <= wv[DW-1:0];
                    endcase
                end
            end
            // A set from the engine beats a same-cycle write-1-to-clear.
            done <= (done & ~done_clr) | done_set;
            if (wr && (word == IRQEN_ADDR) && hit_nch) begin
                irq_en <= wv[NCH-1:0];
            end
            if (wr && (word == TICKDIV_ADDR) && hit_pw) begin
                tickdiv <= wv[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            tick_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tick_pending <= 1'b0;
                    if (tick || tick_pending) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                default: begin
                    if (tick) begin
                        tick_pending <= 1'b1;
                    end
                    if (idx == 3'(NCH - 1)) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= req;
            rdata <= req ? rd_val : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt    <= '0;
            pwm_out <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
            for (int c = 0; c < NCH; c++) begin
                pwm_out[c] <= (pcnt < duty_eff[c]);
            end
        end
    end
endmodule
